inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
// Instruction fetch stage for the RYSY core. Drives the instruction-memory handshake.
// Holds the current instruction in an instruction register (IR).
// Presents decoded fields (opcode, func3, func7, rd, rs1, rs2) to the control unit and the datapath.
// Sits directly upstream of ctrl. Holds the IR while ctrl stalls (LOAD phase 0, STORE).
// Takes branch/jump targets from the ALU.
// PARAMETERS
// RESET_PC  32'h0000_0000  address of first fetch after reset
// NOP_INST  32'h0000_0013  value loaded into IR when no valid instruction (addi x0,x0,0)
// PORTS
// clk          in   1   clock, all state on rising edge
// rst          in   1   synchronous reset, active-high
// imem_req     out  1   fetch request to instruction memory
// imem_addr    out  32  fetch address, word aligned
// imem_ack     in   1   memory returns imem_rdata this cycle
// imem_rdata   in   32  fetched instruction word
// stall        in   1   ctrl holds current instruction (multi-cycle op)
// redirect     in   1   take redirect_pc as next fetch address (taken branch/JAL/JALR)
// redirect_pc  in   32  target address from ALU
// inst_valid   out  1   IR holds a valid instruction
// pc           out  32  address of instruction in IR
// inst         out  32  IR contents
// opcode       out  5   inst[6:2]
// func3        out  3   inst[14:12]
// func7        out  7   inst[31:25]
// rd/rs1/rs2   out  5   inst[11:7] / inst[19:15] / inst[24:20]
// illegal      out  1   inst_valid & (inst[1:0] != 2'b11)
// BEHAVIOUR
// - Reset: state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, inst=NOP_INST, inst_valid=0, imem_req=0.
// - FSM states and transitions:
//   IDLE  -> FETCH unconditionally, next cycle.
//   FETCH -> imem_req=1, imem_addr=fetch_pc. On imem_ack: inst<=imem_rdata, pc<=fetch_pc,
//            inst_valid<=1, go to EXEC. Otherwise stay; req and addr held stable.
//   EXEC  -> imem_req=0. If stall: hold IR, pc and inst_valid.
//            Else if redirect: fetch_pc<={redirect_pc[31:2],2'b00}.
//            Else: fetch_pc<=pc+4.
//            When not stalled: also inst<=NOP_INST, inst_valid<=0, go to FETCH.
// - imem_req and imem_addr are registered-state decodes (no comb path from imem_ack).
// - Latency: imem_ack in cycle N -> inst_valid=1 in cycle N+1.
//   Minimum 2 cycles per instruction (FETCH+EXEC); each memory wait cycle adds 1.
// - Decoded field outputs are combinational slices of the IR.
// - The IR reads NOP_INST whenever inst_valid=0, so ctrl sees OP_IMM to x0 and its load phase never toggles.
// - stall and redirect in the same cycle: stall wins; redirect is ignored and ctrl must re-assert it.
// - redirect/stall outside EXEC: ignored. imem_ack outside FETCH: ignored.
// - Misaligned redirect_pc: bits [1:0] are cleared silently.
// - PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC, next sequential fetch_pc=32'h0000_0000.
// - Reset mid-fetch (rst with imem_req=1, even with imem_ack=1): the returned word is discarded.
//   The IR stays NOP_INST and the next fetch is at RESET_PC.
// - illegal is informational only; the FSM sequence does not change.
// TESTING
// 1 Reset 2 cycles; ack immediately with 32'h0050_0093 @0 -> imem_addr=0 in cycle 2; next cycle inst_valid=1, opcode=5'b00100, rd=1, rs1=0, func3=0, pc=0.
// 2 Three instructions, ack after 2 wait cycles each -> addrs 0,4,8; req/addr stable during waits; inst_valid pulses once per instr.
// 3 In EXEC, redirect=1, redirect_pc=32'h0000_0102 -> next imem_addr=32'h0000_0100; pc after ack=32'h100.
// 4 LOAD in IR, stall=1 for 3 cycles, then redirect+stall 1 cycle -> IR/pc held 4 cycles, imem_req=0; next fetch pc+4.
// 5 rst=1 while imem_req=1 and imem_ack=1 (rdata=32'hDEAD_BEEF) -> inst=NOP_INST, inst_valid=0; next fetch addr RESET_PC.
// 6 RESET_PC=32'hFFFF_FFFC, rdata=32'h0000_0000 -> illegal=1; second fetch addr=32'h0000_0000.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage for the RYSY core.
// Runs the imem handshake, holds the instruction register, and slices out the decoded fields.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'd3;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          inst_d       = imem_rdata;
          pc_d         = fetch_pc_q;
          inst_valid_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // A stall freezes everything, including any redirect asserted alongside it.
        if (!stall) begin
          fetch_pc_d   = redirect ? redirect_aligned : pc_q + 32'd4;
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Request and address decode from registered state only, so no path from imem_ack.
  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign opcode     = inst_q[6:2];
  assign func3      = inst_q[14:12];
  assign func7      = inst_q[31:25];
  assign rd         = inst_q[11:7];
  assign rs1        = inst_q[19:15];
  assign rs2        = inst_q[24:20];
  assign illegal    = inst_valid_q & (inst_q[1:0] != 2'b11);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios, then randomized traffic,
// with two instances (RESET_PC=0 and RESET_PC=FFFF_FFFC) checked against a reference model.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_ack, stall, redirect;
  logic [31:0] imem_rdata, redirect_pc;

  logic        req0, valid0, ill0, req1, valid1, ill1;
  logic [31:0] addr0, pc0, inst0, addr1, pc1, inst1;
  logic [4:0]  opc0, rd0, rs1_0, rs2_0, opc1, rd1, rs1_1, rs2_1;
  logic [2:0]  f3_0, f3_1;
  logic [6:0]  f7_0, f7_1;

  inst_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut0 (
    .clk(clk), .rst(rst), .imem_req(req0), .imem_addr(addr0), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(valid0), .pc(pc0), .inst(inst0), .opcode(opc0), .func3(f3_0), .func7(f7_0),
    .rd(rd0), .rs1(rs1_0), .rs2(rs2_0), .illegal(ill0)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut1 (
    .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(valid1), .pc(pc1), .inst(inst1), .opcode(opc1), .func3(f3_1), .func7(f7_1),
    .rd(rd1), .rs1(rs1_1), .rs2(rs2_1), .illegal(ill1)
  );

  // Reference model: per instance, whether fetching has begun, whether an instruction is held,
  // the pending fetch address, and the held instruction and its address.
  logic [31:0] m_reset_pc [2];
  bit          m_started  [2];
  bit          m_held     [2];
  logic [31:0] m_fetch    [2];
  logic [31:0] m_pc       [2];
  logic [31:0] m_inst     [2];

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic a, input logic [31:0] rdata,
                               input logic s, input logic rdr, input logic [31:0] rpc);
    rst         = r;
    imem_ack    = a;
    imem_rdata  = rdata;
    stall       = s;
    redirect    = rdr;
    redirect_pc = rpc;
  endtask

  task automatic updateModel();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_started[k] = 1'b0;
        m_held[k]    = 1'b0;
        m_fetch[k]   = m_reset_pc[k];
        m_pc[k]      = m_reset_pc[k];
        m_inst[k]    = NOP;
      end else if (!m_started[k]) begin
        m_started[k] = 1'b1;
      end else if (!m_held[k]) begin
        if (imem_ack) begin
          m_inst[k] = imem_rdata;
          m_pc[k]   = m_fetch[k];
          m_held[k] = 1'b1;
        end
      end else if (!stall) begin
        m_fetch[k] = redirect ? {redirect_pc[31:2], 2'b00} : m_pc[k] + 32'd4;
        m_inst[k]  = NOP;
        m_held[k]  = 1'b0;
      end
    end
  endtask

  task automatic checkDut(input int k, input logic req, input logic [31:0] addr, input logic valid,
                          input logic [31:0] pcv, input logic [31:0] instv, input logic [4:0] opc,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rdv,
                          input logic [4:0] rs1v, input logic [4:0] rs2v, input logic ill);
    logic [31:0] mi;
    mi = m_inst[k];
    checkOutput($sformatf("d%0d_req", k),   {31'b0, req},   {31'b0, m_started[k] && !m_held[k]});
    checkOutput($sformatf("d%0d_addr", k),  addr,           m_fetch[k]);
    checkOutput($sformatf("d%0d_valid", k), {31'b0, valid}, {31'b0, m_held[k]});
    checkOutput($sformatf("d%0d_pc", k),    pcv,            m_pc[k]);
    checkOutput($sformatf("d%0d_inst", k),  instv,          mi);
    checkOutput($sformatf("d%0d_opcode", k), {27'b0, opc},  {27'b0, mi[6:2]});
    checkOutput($sformatf("d%0d_func3", k), {29'b0, f3},    {29'b0, mi[14:12]});
    checkOutput($sformatf("d%0d_func7", k), {25'b0, f7},    {25'b0, mi[31:25]});
    checkOutput($sformatf("d%0d_rd", k),    {27'b0, rdv},   {27'b0, mi[11:7]});
    checkOutput($sformatf("d%0d_rs1", k),   {27'b0, rs1v},  {27'b0, mi[19:15]});
    checkOutput($sformatf("d%0d_rs2", k),   {27'b0, rs2v},  {27'b0, mi[24:20]});
    checkOutput($sformatf("d%0d_illegal", k), {31'b0, ill},
                {31'b0, m_held[k] && (mi[1:0] != 2'b11)});
  endtask

  task automatic runCycle();
    @(posedge clk);
    updateModel();
    #1;
    checkDut(0, req0, addr0, valid0, pc0, inst0, opc0, f3_0, f7_0, rd0, rs1_0, rs2_0, ill0);
    checkDut(1, req1, addr1, valid1, pc1, inst1, opc1, f3_1, f7_1, rd1, rs1_1, rs2_1, ill1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    m_reset_pc[0] = 32'h0000_0000;
    m_reset_pc[1] = 32'hFFFF_FFFC;
    for (int k = 0; k < 2; k++) begin
      m_started[k] = 1'b0;
      m_held[k]    = 1'b0;
      m_fetch[k]   = m_reset_pc[k];
      m_pc[k]      = m_reset_pc[k];
      m_inst[k]    = NOP;
    end

    // Reset, then an immediate ack of addi x1,x0,5 at address 0
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    runCycle();
    runCycle();
    checkOutput("t1_reset_inst", inst0, NOP);
    checkOutput("t1_reset_valid", {31'b0, valid0}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    runCycle();
    checkOutput("t1_req", {31'b0, req0}, 32'd1);
    checkOutput("t1_addr", addr0, 32'h0);
    runCycle();
    checkOutput("t1_valid", {31'b0, valid0}, 32'd1);
    checkOutput("t1_opcode", {27'b0, opc0}, 32'b00100);
    checkOutput("t1_rd", {27'b0, rd0}, 32'd1);
    checkOutput("t1_rs1", {27'b0, rs1_0}, 32'd0);
    checkOutput("t1_func3", {29'b0, f3_0}, 32'd0);
    checkOutput("t1_pc", pc0, 32'h0);

    // Three sequential instructions, each acked after two wait cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      runCycle();
      checkOutput("t2_addr", addr0, 32'd4 * (i + 1));
      for (int w = 0; w < 2; w++) begin
        runCycle();
        checkOutput("t2_wait_addr", addr0, 32'd4 * (i + 1));
        checkOutput("t2_wait_req", {31'b0, req0}, 32'd1);
      end
      applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
      runCycle();
      checkOutput("t2_valid", {31'b0, valid0}, 32'd1);
    end

    // Misaligned redirect, then a LOAD fetched at the target
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0102);
    runCycle();
    checkOutput("t3_addr", addr0, 32'h0000_0100);
    applyStimulus(1'b0, 1'b1, 32'h0000_2003, 1'b0, 1'b0, 32'h0);
    runCycle();
    checkOutput("t3_pc", pc0, 32'h0000_0100);

    // Stall three cycles, then stall together with redirect: IR held, redirect dropped
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, (i == 3), 32'h0000_0040);
      runCycle();
      checkOutput("t4_pc_hold", pc0, 32'h0000_0100);
      checkOutput("t4_inst_hold", inst0, 32'h0000_2003);
      checkOutput("t4_req", {31'b0, req0}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    runCycle();
    checkOutput("t4_next_addr", addr0, 32'h0000_0104);

    // Reset while a request is being acked: the returned word is dropped
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    runCycle();
    checkOutput("t5_inst", inst0, NOP);
    checkOutput("t5_valid", {31'b0, valid0}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    runCycle();
    checkOutput("t5_addr0", addr0, 32'h0);
    checkOutput("t5_addr1", addr1, 32'hFFFF_FFFC);

    // Top-of-memory instance: all-zero word is illegal, next fetch wraps to 0
    applyStimulus(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
    runCycle();
    checkOutput("t6_illegal", {31'b0, ill1}, 32'd1);
    checkOutput("t6_pc", pc1, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    runCycle();
    checkOutput("t6_wrap_addr", addr1, 32'h0000_0000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(99) == 0), ($urandom_range(1) == 1), $urandom,
                    ($urandom_range(9) < 3), ($urandom_range(9) < 3), $urandom);
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
